// File: rtl/armleocpu_simple2axi_converter_pkg.sv
// ============================================================================
// Module      : armleocpu_simple2axi_converter_pkg
// Description : Shared state encoding and AXI4 protocol constants for the
//               simple-bus to AXI4 initiator bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package armleocpu_simple2axi_converter_pkg;

  // Bridge sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MISALIGN  = 3'd1,
    S_WRITE_REQ = 3'd2,
    S_WAIT_B    = 3'd3,
    S_READ_REQ  = 3'd4,
    S_WAIT_R    = 3'd5,
    S_DRAIN     = 3'd6
  } state_t;

  // Fixed single-beat AXI4 attributes
  localparam logic [7:0] LEN_SINGLE  = 8'd0;
  localparam logic [2:0] SIZE_4B     = 3'd2;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/armleocpu_simple2axi_converter.sv
// ============================================================================
// Module      : armleocpu_simple2axi_converter
// Description : Simple-bus to AXI4 initiator bridge. Retires one request at a
//               time as a single-beat AXI4 transaction (LEN=0, SIZE=4B, INCR).
//               Misaligned requests are rejected locally with SLVERR.
//               Optional response watchdog: ARMLEOCPU_SIMPLE2AXI_TIMEOUT_EN
//               (reports DECERR, then drains the late response).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module armleocpu_simple2axi_converter
  import armleocpu_simple2axi_converter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 34,
  parameter int ID_WIDTH       = 4,
  parameter int AXI_ID         = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Simple request interface
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  req_done,
  output logic [31:0]           req_rdata,
  output logic [1:0]            req_resp,
  // AXI4 write address
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  // AXI4 write data
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wlast,
  // AXI4 write response
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  input  logic [ID_WIDTH-1:0]   axi_bid,
  // AXI4 read address
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ID_WIDTH-1:0]   axi_arid,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  // AXI4 read data
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic [31:0]           axi_rdata,
  input  logic [ID_WIDTH-1:0]   axi_rid
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;

  // Channel completion: a channel is done once its valid is low or handshakes now
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !axi_awvalid || axi_awready;
  assign w_w_done  = !axi_wvalid  || axi_wready;

  // Constant transaction attributes; address shared by both request channels
  assign axi_awid    = ID_WIDTH'(AXI_ID);
  assign axi_arid    = ID_WIDTH'(AXI_ID);
  assign axi_awlen   = LEN_SINGLE;
  assign axi_arlen   = LEN_SINGLE;
  assign axi_awsize  = SIZE_4B;
  assign axi_arsize  = SIZE_4B;
  assign axi_awburst = BURST_INCR;
  assign axi_arburst = BURST_INCR;
  assign axi_wlast   = 1'b1;
  assign axi_awaddr  = r_addr;
  assign axi_araddr  = r_addr;

`ifdef ARMLEOCPU_SIMPLE2AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_active;
  logic             w_final_hs;
  logic             w_timeout;

  assign w_active   = (r_state == S_WRITE_REQ) || (r_state == S_WAIT_B) ||
                      (r_state == S_READ_REQ)  || (r_state == S_WAIT_R);
  assign w_final_hs = ((r_state == S_WAIT_B) && axi_bvalid) ||
                      ((r_state == S_WAIT_R) && axi_rvalid);
  assign w_timeout  = w_active && !w_final_hs && (r_cnt == C_LIMIT);

  // Sideband IDs and RLAST carry no information for single-beat, fixed-ID traffic
  logic w_unused;
  assign w_unused = ^{axi_bid, axi_rid, axi_rlast};
`else
  logic w_unused;
  assign w_unused = ^{axi_bid, axi_rid, axi_rlast, 32'(TIMEOUT_CYCLES)};
`endif

  // Request sequencer with registered AXI valids/readies and request outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      req_done    <= 1'b0;
      req_rdata   <= '0;
      req_resp    <= RESP_OKAY;
    end else begin
      req_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_address[1:0] != 2'b00) begin
              r_state <= S_MISALIGN;
            end else if (req_write) begin
              r_addr      <= req_address;
              axi_wdata   <= req_wdata;
              axi_wstrb   <= req_wstrb;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              r_state     <= S_WRITE_REQ;
            end else begin
              r_addr      <= req_address;
              axi_arvalid <= 1'b1;
              r_state     <= S_READ_REQ;
            end
          end
        end
        S_MISALIGN: begin
          req_done <= 1'b1;
          req_resp <= RESP_SLVERR;
          r_state  <= S_IDLE;
        end
        S_WRITE_REQ: begin
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            axi_bready <= 1'b1;
            r_state    <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (axi_bvalid) begin
            req_done   <= 1'b1;
            req_resp   <= axi_bresp;
            axi_bready <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_READ_REQ: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            r_state     <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (axi_rvalid) begin
            req_rdata  <= axi_rdata;
            req_resp   <= axi_rresp;
            req_done   <= 1'b1;
            axi_rready <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
`ifdef ARMLEOCPU_SIMPLE2AXI_TIMEOUT_EN
        S_DRAIN: begin
          // Finish any pending request beats, then swallow the late response
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
          if (axi_arvalid && axi_arready) axi_arvalid <= 1'b0;
          if ((axi_bvalid && axi_bready) || (axi_rvalid && axi_rready)) begin
            axi_bready <= 1'b0;
            axi_rready <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
`ifdef ARMLEOCPU_SIMPLE2AXI_TIMEOUT_EN
      // Watchdog overrides the normal flow; the entry cycle counts as the first
      if (r_state == S_IDLE) begin
        r_cnt <= CNT_W'(1);
      end else if (w_active) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        req_done <= 1'b1;
        req_resp <= RESP_DECERR;
        r_state  <= S_DRAIN;
        if ((r_state == S_WRITE_REQ) || (r_state == S_WAIT_B)) axi_bready <= 1'b1;
        else                                                   axi_rready <= 1'b1;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_armleocpu_simple2axi_converter.sv
// ============================================================================
// Module      : tb_armleocpu_simple2axi_converter
// Description : Directed self-checking bench for the simple-to-AXI4 bridge.
//               Watchdog scenario runs when ARMLEOCPU_SIMPLE2AXI_TIMEOUT_EN
//               is defined (TIMEOUT_CYCLES = 16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_armleocpu_simple2axi_converter;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [33:0] req_address;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_done;
  logic [31:0] req_rdata;
  logic [1:0]  req_resp;
  logic        axi_awvalid, axi_awready;
  logic [3:0]  axi_awid;
  logic [33:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [3:0]  axi_bid;
  logic        axi_arvalid, axi_arready;
  logic [3:0]  axi_arid;
  logic [33:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid, axi_rready;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [31:0] axi_rdata;
  logic [3:0]  axi_rid;

  armleocpu_simple2axi_converter #(
    .ADDR_WIDTH(34), .ID_WIDTH(4), .AXI_ID(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_done(req_done),
    .req_rdata(req_rdata), .req_resp(req_resp),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rdata(axi_rdata), .axi_rid(axi_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Per-transaction observations collected by the slave driver
  int          t_lat, t_aw, t_w, t_ar, t_done, t_viol, t_indep, t_const_bad;
  logic [33:0] t_awaddr, t_araddr;
  logic [31:0] t_wdata, t_rdata;
  logic [3:0]  t_wstrb;
  logic [1:0]  t_resp;

  task automatic idle_slave();
    axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
    axi_bvalid  = 1'b0; axi_rvalid = 1'b0;
  endtask

  // Issue one request and act as an AXI slave with per-channel delays.
  // Inputs change and handshakes are judged on the falling edge.
  task automatic run_txn(input logic wr, input logic [33:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int aw_dly, input int w_dly,
                         input int ar_dly, input int b_dly, input int r_dly,
                         input logic [1:0] bresp_i, input logic [1:0] rresp_i,
                         input logic [31:0] rdata_i);
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic b_fin = 1'b0, r_fin = 1'b0;
    logic pend_aw = 1'b0, pend_w = 1'b0, pend_ar = 1'b0;
    t_lat = -1; t_aw = 0; t_w = 0; t_ar = 0; t_done = 0; t_viol = 0; t_indep = 0;
    t_const_bad = 0; t_awaddr = '0; t_araddr = '0; t_wdata = '0; t_wstrb = '0;
    t_rdata = '0; t_resp = '0;
    @(negedge clk);
    idle_slave();
    req_valid = 1'b1; req_write = wr; req_address = addr; req_wdata = wd; req_wstrb = ws;
    axi_bresp = bresp_i; axi_rresp = rresp_i; axi_rdata = rdata_i;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (pend_aw && !axi_awvalid) t_viol++;
      if (pend_w  && !axi_wvalid)  t_viol++;
      if (pend_ar && !axi_arvalid) t_viol++;
      if (axi_awvalid != axi_wvalid) t_indep = 1;
      if (req_done) begin
        t_done++;
        if (t_lat < 0) begin
          t_lat = cyc; t_rdata = req_rdata; t_resp = req_resp;
        end
        req_valid = 1'b0;
      end
      if (t_lat >= 0 && cyc >= t_lat + 3) break;
      axi_awready = axi_awvalid && (aw_wait >= aw_dly);
      if (axi_awvalid) aw_wait++;
      axi_wready  = axi_wvalid && (w_wait >= w_dly);
      if (axi_wvalid) w_wait++;
      axi_arready = axi_arvalid && (ar_wait >= ar_dly);
      if (axi_arvalid) ar_wait++;
      axi_bvalid = (t_aw > 0) && (t_w > 0) && !b_fin && (b_wait >= b_dly);
      if ((t_aw > 0) && (t_w > 0)) b_wait++;
      axi_rvalid = (t_ar > 0) && !r_fin && (r_wait >= r_dly);
      if (t_ar > 0) r_wait++;
      if (axi_awvalid && axi_awready) begin
        t_aw++; t_awaddr = axi_awaddr;
        if (axi_awlen !== 8'd0 || axi_awsize !== 3'd2 || axi_awburst !== 2'b01 ||
            axi_awid !== 4'd0) t_const_bad++;
      end
      if (axi_wvalid && axi_wready) begin
        t_w++; t_wdata = axi_wdata; t_wstrb = axi_wstrb;
        if (axi_wlast !== 1'b1) t_const_bad++;
      end
      if (axi_arvalid && axi_arready) begin
        t_ar++; t_araddr = axi_araddr;
        if (axi_arlen !== 8'd0 || axi_arsize !== 3'd2 || axi_arburst !== 2'b01 ||
            axi_arid !== 4'd0) t_const_bad++;
      end
      if (axi_bvalid && axi_bready) b_fin = 1'b1;
      if (axi_rvalid && axi_rready) r_fin = 1'b1;
      pend_aw = axi_awvalid && !axi_awready;
      pend_w  = axi_wvalid  && !axi_wready;
      pend_ar = axi_arvalid && !axi_arready;
    end
    idle_slave();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, req_done} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, req_done});
    end
    vectors++;
    if (req_rdata !== 32'h0 || req_resp !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h resp=%b expected 0/00", req_rdata, req_resp);
    end
    rst_n = 1'b1;
  endtask

  // Zero-wait write: done three cycles after the request
  task automatic test_write_basic();
    run_txn(1'b1, 34'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    vectors++;
    if (t_lat !== 3 || t_done !== 1) begin
      miscompares++; $display("FAIL wr_latency: got lat=%0d dones=%0d expected 3/1", t_lat, t_done);
    end
    vectors++;
    if (t_aw !== 1 || t_w !== 1 || t_ar !== 0 || t_indep !== 0) begin
      miscompares++;
      $display("FAIL wr_beats: got aw=%0d w=%0d ar=%0d indep=%0d expected 1/1/0/0", t_aw, t_w, t_ar, t_indep);
    end
    vectors++;
    if (t_awaddr !== 34'h10 || t_wdata !== 32'hDEADBEEF || t_wstrb !== 4'hF || t_const_bad !== 0) begin
      miscompares++;
      $display("FAIL wr_fields: got addr=%h data=%h strb=%h cbad=%0d expected 10/deadbeef/f/0",
               t_awaddr, t_wdata, t_wstrb, t_const_bad);
    end
    vectors++;
    if (t_resp !== 2'b00) begin
      miscompares++; $display("FAIL wr_resp: got %b expected 00", t_resp);
    end
  endtask

  // Read with five slave wait cycles before RVALID
  task automatic test_read_wait();
    run_txn(1'b0, 34'h20, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b00, 2'b00, 32'h12345678);
    vectors++;
    if (t_rdata !== 32'h12345678 || t_resp !== 2'b00) begin
      miscompares++; $display("FAIL rd_data: got %h/%b expected 12345678/00", t_rdata, t_resp);
    end
    vectors++;
    if (t_lat !== 8 || t_done !== 1) begin
      miscompares++; $display("FAIL rd_latency: got lat=%0d dones=%0d expected 8/1", t_lat, t_done);
    end
    vectors++;
    if (t_ar !== 1 || t_aw !== 0 || t_araddr !== 34'h20 || t_const_bad !== 0 || t_viol !== 0) begin
      miscompares++;
      $display("FAIL rd_beats: got ar=%0d aw=%0d addr=%h cbad=%0d viol=%0d expected 1/0/20/0/0",
               t_ar, t_aw, t_araddr, t_const_bad, t_viol);
    end
  endtask

  // W accepted four cycles before AW, then SLVERR on B
  task automatic test_write_split();
    run_txn(1'b1, 34'h34, 32'hCAFEF00D, 4'h5, 4, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0);
    vectors++;
    if (t_indep !== 1 || t_viol !== 0 || t_aw !== 1 || t_w !== 1) begin
      miscompares++;
      $display("FAIL split_beats: got indep=%0d viol=%0d aw=%0d w=%0d expected 1/0/1/1",
               t_indep, t_viol, t_aw, t_w);
    end
    vectors++;
    if (t_resp !== 2'b10 || t_lat !== 7) begin
      miscompares++; $display("FAIL split_resp: got resp=%b lat=%0d expected 10/7", t_resp, t_lat);
    end
    vectors++;
    if (t_rdata !== 32'h12345678) begin
      miscompares++; $display("FAIL rdata_hold: got %h expected 12345678", t_rdata);
    end
  endtask

  // Misaligned read and write never reach AXI
  task automatic test_misalign();
    run_txn(1'b0, 34'h22, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    vectors++;
    if (t_ar !== 0 || t_lat !== 2 || t_resp !== 2'b10 || t_done !== 1) begin
      miscompares++;
      $display("FAIL misalign_rd: got ar=%0d lat=%0d resp=%b dones=%0d expected 0/2/10/1",
               t_ar, t_lat, t_resp, t_done);
    end
    run_txn(1'b1, 34'h13, 32'h55, 4'h1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    vectors++;
    if (t_aw !== 0 || t_w !== 0 || t_lat !== 2 || t_resp !== 2'b10) begin
      miscompares++;
      $display("FAIL misalign_wr: got aw=%0d w=%0d lat=%0d resp=%b expected 0/0/2/10",
               t_aw, t_w, t_lat, t_resp);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 34'h3_0000_0100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'hA5A55A5A);
    vectors++;
    if (t_lat !== 3 || t_rdata !== 32'hA5A55A5A || t_resp !== 2'b11 || t_araddr !== 34'h3_0000_0100) begin
      miscompares++;
      $display("FAIL b2b_read: got lat=%0d data=%h resp=%b addr=%h expected 3/a5a55a5a/11/300000100",
               t_lat, t_rdata, t_resp, t_araddr);
    end
    run_txn(1'b1, 34'h44, 32'h0BADF00D, 4'h8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    vectors++;
    if (t_lat !== 3 || t_resp !== 2'b00 || t_wdata !== 32'h0BADF00D || t_wstrb !== 4'h8) begin
      miscompares++;
      $display("FAIL b2b_write: got lat=%0d resp=%b data=%h strb=%h expected 3/00/0badf00d/8",
               t_lat, t_resp, t_wdata, t_wstrb);
    end
  endtask

  // Reset while waiting for R, then a clean read proves the bridge is idle
  task automatic test_reset_midflight();
    @(negedge clk);
    idle_slave();
    req_valid = 1'b1; req_write = 1'b0; req_address = 34'h40;
    @(negedge clk);
    axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0;
    vectors++;
    if (axi_rready !== 1'b1 || axi_arvalid !== 1'b0) begin
      miscompares++; $display("FAIL midflight_wait_r: got rready=%b arvalid=%b expected 1/0", axi_rready, axi_arvalid);
    end
    rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, req_done} !== 6'b0 ||
        req_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midflight_reset: got ctl=%b rdata=%h expected 000000/0",
               {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, req_done}, req_rdata);
    end
    rst_n = 1'b1;
    run_txn(1'b0, 34'h48, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h600DCAFE);
    vectors++;
    if (t_lat !== 3 || t_rdata !== 32'h600DCAFE || t_done !== 1) begin
      miscompares++;
      $display("FAIL post_reset_read: got lat=%0d data=%h dones=%0d expected 3/600dcafe/1",
               t_lat, t_rdata, t_done);
    end
  endtask

`ifdef ARMLEOCPU_SIMPLE2AXI_TIMEOUT_EN
  task automatic test_timeout();
    int late_dones = 0;
    run_txn(1'b0, 34'h80, 32'h0, 4'h0, 0, 0, 1000, 0, 0, 2'b00, 2'b00, 32'h0);
    vectors++;
    if (t_lat !== 16 || t_resp !== 2'b11 || t_ar !== 0 || t_done !== 1) begin
      miscompares++;
      $display("FAIL timeout_done: got lat=%0d resp=%b ar=%0d dones=%0d expected 16/11/0/1",
               t_lat, t_resp, t_ar, t_done);
    end
    vectors++;
    if (axi_arvalid !== 1'b1 || axi_rready !== 1'b1) begin
      miscompares++; $display("FAIL drain_hold: got arvalid=%b rready=%b expected 1/1", axi_arvalid, axi_rready);
    end
    axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0;
    if (req_done) late_dones++;
    axi_rvalid = 1'b1; axi_rdata = 32'hBAD0BAD0; axi_rresp = 2'b00;
    @(negedge clk);
    axi_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (req_done) late_dones++;
      @(negedge clk);
    end
    vectors++;
    if (late_dones !== 0 || req_rdata === 32'hBAD0BAD0 || axi_rready !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_discard: got dones=%0d rdata=%h rready=%b expected 0/not-bad0bad0/0",
               late_dones, req_rdata, axi_rready);
    end
    run_txn(1'b0, 34'h84, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h11223344);
    vectors++;
    if (t_lat !== 3 || t_rdata !== 32'h11223344) begin
      miscompares++; $display("FAIL post_drain_read: got lat=%0d data=%h expected 3/11223344", t_lat, t_rdata);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
    req_wdata = '0; req_wstrb = '0;
    axi_bresp = '0; axi_bid = '0; axi_rresp = '0; axi_rlast = 1'b1;
    axi_rdata = '0; axi_rid = '0;
    idle_slave();
    test_reset();
    test_write_basic();
    test_read_wait();
    test_write_split();
    test_misalign();
    test_back_to_back();
    test_reset_midflight();
`ifdef ARMLEOCPU_SIMPLE2AXI_TIMEOUT_EN
    test_timeout();
`endif
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
